// File: rtl/hazard_forward_unit.sv
// Forwarding and hazard controller. It shadows the EX and MEM destinations, drives the bypass selects,
// and raises load-use and multi-cycle-load stalls. Define HAZARD_ZERO_REG_EN to hard-wire register 0 to zero.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 3,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_LAT   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           dc_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]  dc_src,
    input  logic [NUM_SRC-1:0]             dc_src_used,
    input  logic [REG_ADDR_W-1:0]          dc_rd,
    input  logic                           dc_wr_en,
    input  logic                           dc_is_load,
    input  logic                           flush,
    output logic [2*NUM_SRC-1:0]           dc_fwd_sel,
    output logic [NUM_SRC-1:0]             alu_fwd,
    output logic                           stall,
    output logic                           mem_hold
);

    localparam logic [2:0] LP_WAIT_INIT = 3'(LOAD_LAT - 1);

    logic                          r_ex_v;
    logic [REG_ADDR_W-1:0]         r_ex_rd;
    logic                          r_ex_is_load;
    logic [NUM_SRC*REG_ADDR_W-1:0] r_ex_src;
    logic [NUM_SRC-1:0]            r_ex_src_used;
    logic                          r_mem_v;
    logic [REG_ADDR_W-1:0]         r_mem_rd;
    logic                          r_mem_is_load;
    logic [2:0]                    r_wait_cnt;

    logic [NUM_SRC-1:0]            w_ex_hit;
    logic [NUM_SRC-1:0]            w_mem_hit;
    logic                          w_wait_zero;
    logic                          w_load_use;
    logic                          w_dc_wr;

`ifdef HAZARD_ZERO_REG_EN
    // A write to r0 is never tracked, so r0 can neither forward nor stall.
    assign w_dc_wr = dc_wr_en & (dc_rd != '0);
`else
    assign w_dc_wr = dc_wr_en;
`endif

    assign w_wait_zero = (r_wait_cnt == 3'd0);

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [REG_ADDR_W-1:0] w_src;
        logic [REG_ADDR_W-1:0] w_ex_src;

        assign w_src        = dc_src[s*REG_ADDR_W +: REG_ADDR_W];
        assign w_ex_src     = r_ex_src[s*REG_ADDR_W +: REG_ADDR_W];
        assign w_ex_hit[s]  = r_ex_v & dc_src_used[s] & (r_ex_rd == w_src);
        assign w_mem_hit[s] = r_mem_v & dc_src_used[s] & (r_mem_rd == w_src);

        // EX is the youngest producer, so it wins over MEM.
        assign dc_fwd_sel[2*s +: 2] = (w_ex_hit[s] & ~r_ex_is_load)  ? 2'd1 :
                                      (w_mem_hit[s] & w_wait_zero)   ? 2'd2 : 2'd0;

        assign alu_fwd[s] = r_ex_v & r_ex_src_used[s] & r_mem_v &
                            (r_mem_rd == w_ex_src) & w_wait_zero;
    end

    assign w_load_use = dc_valid & ~flush & r_ex_is_load & (|w_ex_hit);
    assign mem_hold   = ~w_wait_zero;
    assign stall      = w_load_use | mem_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_v        <= 1'b0;
            r_ex_rd       <= '0;
            r_ex_is_load  <= 1'b0;
            r_ex_src      <= '0;
            r_ex_src_used <= '0;
            r_mem_v       <= 1'b0;
            r_mem_rd      <= '0;
            r_mem_is_load <= 1'b0;
            r_wait_cnt    <= 3'd0;
        end else if (mem_hold) begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
        end else begin
            r_mem_v       <= r_ex_v;
            r_mem_rd      <= r_ex_rd;
            r_mem_is_load <= r_ex_is_load;
            if (r_ex_v & r_ex_is_load) begin
                r_wait_cnt <= LP_WAIT_INIT;
            end
            r_ex_v        <= ~(w_load_use | flush | ~dc_valid | ~w_dc_wr);
            r_ex_rd       <= dc_rd;
            r_ex_is_load  <= dc_is_load;
            r_ex_src      <= dc_src;
            r_ex_src_used <= dc_src_used;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: one instance with LOAD_LAT=1, one with LOAD_LAT=3, shared stimulus.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       dc_valid;
    logic [5:0] dc_src;
    logic [1:0] dc_src_used;
    logic [2:0] dc_rd;
    logic       dc_wr_en;
    logic       dc_is_load;
    logic       flush;

    logic [3:0] a_sel, b_sel;
    logic [1:0] a_alu, b_alu;
    logic       a_stall, b_stall, a_hold, b_hold;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .dc_valid(dc_valid), .dc_src(dc_src),
        .dc_src_used(dc_src_used), .dc_rd(dc_rd), .dc_wr_en(dc_wr_en),
        .dc_is_load(dc_is_load), .flush(flush), .dc_fwd_sel(a_sel),
        .alu_fwd(a_alu), .stall(a_stall), .mem_hold(a_hold)
    );

    hazard_forward_unit #(.REG_ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .dc_valid(dc_valid), .dc_src(dc_src),
        .dc_src_used(dc_src_used), .dc_rd(dc_rd), .dc_wr_en(dc_wr_en),
        .dc_is_load(dc_is_load), .flush(flush), .dc_fwd_sel(b_sel),
        .alu_fwd(b_alu), .stall(b_stall), .mem_hold(b_hold)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s0, input logic [2:0] s1,
                         input logic [1:0] used, input logic [2:0] rd,
                         input logic wr, input logic ld, input logic fl);
        dc_valid    = v;
        dc_src      = {s1, s0};
        dc_src_used = used;
        dc_rd       = rd;
        dc_wr_en    = wr;
        dc_is_load  = ld;
        flush       = fl;
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 3'd3, 3'd3, 2'b11, 3'd3, 1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            if (i == 1) rst = 1'b0;
            #2;
            checks++; if (a_sel !== 4'd0)  begin errors++; $display("FAIL reset_a_sel cyc%0d got %h want 0", i, a_sel); end
            checks++; if (a_alu !== 2'd0)  begin errors++; $display("FAIL reset_a_alu cyc%0d got %h want 0", i, a_alu); end
            checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_a_stall cyc%0d got %b want 0", i, a_stall); end
            checks++; if (a_hold !== 1'b0)  begin errors++; $display("FAIL reset_a_hold cyc%0d got %b want 0", i, a_hold); end
            checks++; if (b_sel !== 4'd0)  begin errors++; $display("FAIL reset_b_sel cyc%0d got %h want 0", i, b_sel); end
            checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL reset_b_stall cyc%0d got %b want 0", i, b_stall); end
            if (i == 0) tick();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 3'd0, 3'd0, 2'b00, 3'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd3, 3'd0, 2'b01, 3'd6, 1'b1, 1'b0, 1'b0);
        checks++; if (a_sel[1:0] !== 2'd1) begin errors++; $display("FAIL b2b_ex_fwd got %0d want 1", a_sel[1:0]); end
        checks++; if (a_stall !== 1'b0)    begin errors++; $display("FAIL b2b_stall got %b want 0", a_stall); end
        tick();
        drive(1'b1, 3'd3, 3'd0, 2'b01, 3'd1, 1'b1, 1'b0, 1'b0);
        checks++; if (a_sel !== 4'b0010) begin errors++; $display("FAIL b2b_mem_fwd got %b want 0010", a_sel); end
        checks++; if (a_alu !== 2'b01)   begin errors++; $display("FAIL b2b_alu_fwd got %b want 01", a_alu); end
        checks++; if (b_alu !== 2'b01)   begin errors++; $display("FAIL b2b_alu_fwd_lat3 got %b want 01", b_alu); end
    endtask

    task automatic test_same_rd();
        do_reset();
        drive(1'b1, 3'd0, 3'd0, 2'b00, 3'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd0, 3'd0, 2'b00, 3'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd5, 3'd5, 2'b10, 3'd1, 1'b0, 1'b0, 1'b0);
        checks++; if (a_sel !== 4'b0100) begin errors++; $display("FAIL same_rd_sel got %b want 0100", a_sel); end
        checks++; if (b_sel !== 4'b0100) begin errors++; $display("FAIL same_rd_sel_lat3 got %b want 0100", b_sel); end
    endtask

    task automatic test_load_use_lat1();
        do_reset();
        drive(1'b1, 3'd0, 3'd0, 2'b00, 3'd2, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3'd2, 3'd0, 2'b01, 3'd7, 1'b1, 1'b0, 1'b0);
        checks++; if (a_stall !== 1'b1)    begin errors++; $display("FAIL lu1_stall got %b want 1", a_stall); end
        checks++; if (a_hold !== 1'b0)     begin errors++; $display("FAIL lu1_hold0 got %b want 0", a_hold); end
        checks++; if (a_sel[1:0] !== 2'd0) begin errors++; $display("FAIL lu1_sel0 got %0d want 0", a_sel[1:0]); end
        tick();
        #2;
        checks++; if (a_stall !== 1'b0)    begin errors++; $display("FAIL lu1_stall_drop got %b want 0", a_stall); end
        checks++; if (a_hold !== 1'b0)     begin errors++; $display("FAIL lu1_hold1 got %b want 0", a_hold); end
        checks++; if (a_sel[1:0] !== 2'd2) begin errors++; $display("FAIL lu1_mem_fwd got %0d want 2", a_sel[1:0]); end
    endtask

    task automatic test_load_use_lat3();
        int  stall_n = 0;
        int  hold_n  = 0;
        bit  done    = 1'b0;
        do_reset();
        drive(1'b1, 3'd0, 3'd0, 2'b00, 3'd4, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3'd4, 3'd0, 2'b01, 3'd7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10 && !done; i++) begin
            #2;
            if (b_stall) begin
                stall_n++;
                if (b_hold) hold_n++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
        checks++; if (done !== 1'b1)       begin errors++; $display("FAIL lu3_timeout got stall still high want release"); end
        checks++; if (stall_n !== 3)       begin errors++; $display("FAIL lu3_stall_cycles got %0d want 3", stall_n); end
        checks++; if (hold_n !== 2)        begin errors++; $display("FAIL lu3_hold_cycles got %0d want 2", hold_n); end
        checks++; if (b_sel[1:0] !== 2'd2) begin errors++; $display("FAIL lu3_mem_fwd got %0d want 2", b_sel[1:0]); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 3'd0, 3'd0, 2'b00, 3'd2, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3'd2, 3'd0, 2'b01, 3'd7, 1'b1, 1'b0, 1'b1);
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", a_stall); end
        checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL flush_stall_lat3 got %b want 0", b_stall); end
        tick();
        drive(1'b1, 3'd7, 3'd2, 2'b11, 3'd1, 1'b0, 1'b0, 1'b0);
        checks++; if (a_sel !== 4'b1000) begin errors++; $display("FAIL flush_bubble_sel got %b want 1000", a_sel); end
        checks++; if (a_stall !== 1'b0)  begin errors++; $display("FAIL flush_after_stall got %b want 0", a_stall); end
        checks++; if (b_sel !== 4'b0000) begin errors++; $display("FAIL flush_lat3_sel got %b want 0000", b_sel); end
        checks++; if (b_hold !== 1'b1)   begin errors++; $display("FAIL flush_lat3_hold got %b want 1", b_hold); end
        checks++; if (b_stall !== 1'b1)  begin errors++; $display("FAIL flush_lat3_stall got %b want 1", b_stall); end
    endtask

    task automatic test_zero_reg();
        logic [1:0] exp_sel;
        logic       exp_stall;
`ifdef HAZARD_ZERO_REG_EN
        exp_sel   = 2'd0;
        exp_stall = 1'b0;
`else
        exp_sel   = 2'd1;
        exp_stall = 1'b1;
`endif
        do_reset();
        drive(1'b1, 3'd0, 3'd0, 2'b00, 3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd0, 3'd0, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0);
        checks++; if (a_sel[1:0] !== exp_sel) begin errors++; $display("FAIL zero_fwd got %0d want %0d", a_sel[1:0], exp_sel); end
        checks++; if (a_stall !== 1'b0)       begin errors++; $display("FAIL zero_alu_stall got %b want 0", a_stall); end
        do_reset();
        drive(1'b1, 3'd0, 3'd0, 2'b00, 3'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 3'd0, 3'd0, 2'b01, 3'd1, 1'b1, 1'b0, 1'b0);
        checks++; if (a_stall !== exp_stall) begin errors++; $display("FAIL zero_load_stall got %b want %b", a_stall, exp_stall); end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_same_rd();
        test_load_use_lat1();
        test_load_use_lat3();
        test_flush();
        test_zero_reg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised forwarding and hazard controller for the pipelined datapath. It sits beside the ID/EX/MEM pipeline registers and keeps its own shadow copy of in-flight destination registers for the EX and MEM stages. It drives the decode-stage and ALU-input bypass selects, generates load-use and multi-cycle-load stalls, and honours branch flushes. It replaces the purely combinational equality-compare forwarding controller: it qualifies each match with valid/write-enable, prioritises the youngest producer, scales to N sources, and tracks load latency.

Parameters:
REG_ADDR_W, 3, register address width (2**REG_ADDR_W architectural registers)
NUM_SRC, 2, source operands per instruction (1..4)
LOAD_LAT, 1, cycles a load spends in MEM before its data is forwardable (1..7)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active high
dc_valid  in  1  decode stage holds a real instruction
dc_src  in  NUM_SRC*REG_ADDR_W  decode source addresses; src k at [k*REG_ADDR_W +: REG_ADDR_W]
dc_src_used  in  NUM_SRC  per-source "operand actually read"
dc_rd  in  REG_ADDR_W  decode destination
dc_wr_en  in  1  decode instruction writes dc_rd
dc_is_load  in  1  decode instruction is a load
flush  in  1  branch taken: squash the decode-stage instruction
dc_fwd_sel  out  2*NUM_SRC  per source: 0 = regfile, 1 = EX result, 2 = MEM result (3 never driven)
alu_fwd  out  NUM_SRC  per EX operand: 1 = take MEM result
stall  out  1  hold PC and IF/DC registers
mem_hold  out  1  hold the EX/MEM and MEM/WB registers (multi-cycle load)

Behaviour:
- Interface fixed: single clock clk; rst synchronous, active high.
- Shadow state:
  - ex_q = {v, rd, is_load, src[NUM_SRC], src_used}.
  - mem_q = {v, rd, is_load}.
  - wait_cnt, width 3.
- Reset: all v = 0 and wait_cnt = 0. All outputs are therefore 0 in the cycle after rst is sampled high. Reset mid-stall aborts the stall.
- All outputs are combinational from shadow state and current inputs (0-cycle latency).
- An entry matches source s only if: entry.v = 1, src_used[s] = 1, and entry.rd == src[s].
- dc_fwd_sel[s]:
  - 1 if ex_q matches and ex_q.is_load = 0.
  - Else 2 if mem_q matches and wait_cnt == 0.
  - Else 0.
  - The EX match is youngest and wins over MEM.
- alu_fwd[s] = mem_q match against ex_q.src[s]/ex_q.src_used[s], gated by ex_q.v and wait_cnt == 0.
- load_use = dc_valid & !flush & (some source matches ex_q with ex_q.is_load = 1).
- mem_hold = (wait_cnt != 0).
- stall = load_use | mem_hold.
- Clock update, in priority order:
  1. rst: clear all state.
  2. mem_hold: ex_q and mem_q hold; wait_cnt decrements.
  3. Otherwise:
     - mem_q <= ex_q (v, rd, is_load).
     - If ex_q.v & ex_q.is_load, wait_cnt <= LOAD_LAT-1.
     - ex_q <= bubble (v = 0) if load_use or flush or !dc_valid or !dc_wr_en. Otherwise ex_q <= decode fields with v = 1.
     - ex_q.src/src_used always capture the decode values, with v gating their use. alu_fwd uses ex_q.v.
- LOAD_LAT = 1: wait_cnt never leaves 0. A load-use costs exactly one bubble, then fwd = 2.
- Flush during load_use: flush wins. stall drops unless mem_hold is set, because the older load in MEM still waits.
- Simultaneous EX and MEM writes to the same rd: EX is selected.

Optional Feature:
HAZARD_ZERO_REG_EN:
- Defined: register address 0 is hard-wired zero. Any source or destination equal to 0 never matches, so it causes no forward and no stall.
- Undefined: register 0 is treated like any other register.

Test Plan:
1. Reset: hold rst 2 cycles with dc_valid = 1 and matching addresses -> all outputs 0 during and one cycle after reset.
2. Back-to-back ALU ops: cycle 0 writes r3; cycle 1 reads src0 = r3 -> dc_fwd_sel[1:0] = 1. Cycle 2, reading r3 again -> 2. Cycle 2 EX operand -> alu_fwd[0] = 1.
3. Same-rd priority: MEM and EX both hold r5, decode reads r5 on src1 -> dc_fwd_sel[3:2] = 1, not 2.
4. Load-use, LOAD_LAT = 1: load r2, then consumer of r2 -> stall = 1 for exactly 1 cycle, then dc_fwd_sel = 2, mem_hold never set.
5. LOAD_LAT = 3: load r4 plus consumer -> stall high 3 cycles, mem_hold high 2 cycles, then fwd = 2.
6. Flush plus zero register:
   - Flush asserted during load_use with LOAD_LAT = 1 -> stall = 0 that cycle and ex_q is a bubble.
   - With HAZARD_ZERO_REG_EN defined, write r0 then read r0 -> fwd = 0, stall = 0.
